// File: rtl/cp0_regfile_pkg.sv
// rtl/cp0_regfile_pkg.sv - CP0 register addresses, excodes, reset values and WB->CP0 bus layout
// Shared by cp0_regfile and cp0_timer; the timer exists only under CP0_TIMER_INT_EN.
package cp0_regfile_pkg;

  localparam int WB_TO_CP0_REGISTER_BUS_WD = 110;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  // Field order fixes the bit positions: ex at [109] down to eret at [0].
  typedef struct packed {
    logic        ex;
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic        bd;
    logic [31:0] pc;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] wdata;
    logic        eret;
  } cp0_bus_t;

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer producing the TI flag
// Count advances on every second cycle; TI latches on Count == Compare until Compare is rewritten.
module cp0_timer
  import cp0_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick    <= 1'b0;
      count   <= 32'd0;
      compare <= 32'd0;
      ti      <= 1'b0;
    end else begin
      tick <= ~tick;
      if (count_we) begin
        count <= wdata;
      end else if (tick) begin
        count <= count + 32'd1;
      end
      // A Compare write acknowledges the interrupt and wins over a match that cycle.
      if (compare_we) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (count == compare) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - CP0 register file fed by the WB-stage CP0 bus
// Define CP0_TIMER_INT_EN to add Count/Compare and the timer interrupt on IP[7].
module cp0_regfile
  import cp0_regfile_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [WB_TO_CP0_REGISTER_BUS_WD-1:0] wb_to_cp0_register_bus,
  input  logic [5:0]                           ext_int_in,
  output logic [31:0]                          cp0_rdata,
  output logic [31:0]                          cp0_epc,
  output logic                                 has_int,
  output logic                                 status_exl
);

  cp0_bus_t bus;
  assign bus = wb_to_cp0_register_bus;

  logic do_ex, do_eret, do_mtc0;
  assign do_ex   = bus.ex;
  assign do_eret = bus.eret & ~bus.ex;
  assign do_mtc0 = bus.mtc0_we & ~bus.ex & ~bus.eret;

  logic [7:0]  status_im;
  logic        status_ie;
  logic        exl;
  logic        cause_bd;
  logic [4:0]  cause_excode;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;
  logic [31:0] epc;
  logic [31:0] badvaddr;

  logic [31:0] timer_count;
  logic [31:0] timer_compare;
  logic        timer_ti;

`ifdef CP0_TIMER_INT_EN
  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (do_mtc0 && bus.cp0_addr == CP0_COUNT),
    .compare_we (do_mtc0 && bus.cp0_addr == CP0_COMPARE),
    .wdata      (bus.wdata),
    .count      (timer_count),
    .compare    (timer_compare),
    .ti         (timer_ti)
  );
`else
  assign timer_count   = 32'd0;
  assign timer_compare = 32'd0;
  assign timer_ti      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      status_im    <= 8'd0;
      status_ie    <= 1'b0;
      exl          <= 1'b0;
      cause_bd     <= 1'b0;
      cause_excode <= 5'd0;
      cause_ip_hw  <= 6'd0;
      cause_ip_sw  <= 2'd0;
      epc          <= 32'd0;
      badvaddr     <= 32'd0;
    end else begin
      cause_ip_hw <= ext_int_in;
      if (do_ex) begin
        // A nested exception keeps the EPC/BD of the one being handled.
        if (!exl) begin
          epc      <= bus.bd ? bus.pc - 32'd4 : bus.pc;
          cause_bd <= bus.bd;
        end
        exl          <= 1'b1;
        cause_excode <= bus.excode;
        if (bus.excode == EXC_ADEL || bus.excode == EXC_ADES) begin
          badvaddr <= bus.badvaddr;
        end
      end else if (do_eret) begin
        exl <= 1'b0;
      end else if (do_mtc0) begin
        case (bus.cp0_addr)
          CP0_STATUS: begin
            status_im <= bus.wdata[15:8];
            exl       <= bus.wdata[1];
            status_ie <= bus.wdata[0];
          end
          CP0_CAUSE: cause_ip_sw <= bus.wdata[9:8];
          CP0_EPC:   epc         <= bus.wdata;
          default: ;
        endcase
      end
    end
  end

  logic [7:0]  cause_ip;
  logic [31:0] status_rd;
  logic [31:0] cause_rd;

  assign cause_ip  = {cause_ip_hw[5] | timer_ti, cause_ip_hw[4:0], cause_ip_sw};
  assign status_rd = {9'd0, 1'b1, 6'd0, status_im, 6'd0, exl, status_ie};
  assign cause_rd  = {cause_bd, timer_ti, 14'd0, cause_ip, 1'b0, cause_excode, 2'b00};

  always_comb begin
    cp0_rdata = 32'd0;
    case (bus.cp0_addr)
      CP0_BADVADDR: cp0_rdata = badvaddr;
      CP0_COUNT:    cp0_rdata = timer_count;
      CP0_COMPARE:  cp0_rdata = timer_compare;
      CP0_STATUS:   cp0_rdata = status_rd;
      CP0_CAUSE:    cp0_rdata = cause_rd;
      CP0_EPC:      cp0_rdata = epc;
      default:      cp0_rdata = 32'd0;
    endcase
  end

  assign cp0_epc    = epc;
  assign status_exl = exl;
  assign has_int    = (|(cause_ip & status_im)) & status_ie & ~exl;

endmodule

// File: tb/tb_cp0_regfile.sv
// tb/tb_cp0_regfile.sv - self-checking bench for cp0_regfile (timer checks under CP0_TIMER_INT_EN)
module tb_cp0_regfile;

  logic         clk = 1'b0;
  logic         reset;
  logic [109:0] bus;
  logic [5:0]   ext_int_in;
  logic [31:0]  cp0_rdata;
  logic [31:0]  cp0_epc;
  logic         has_int;
  logic         status_exl;

  int checks = 0;
  int failures = 0;

  cp0_regfile dut (
    .clk                    (clk),
    .reset                  (reset),
    .wb_to_cp0_register_bus (bus),
    .ext_int_in             (ext_int_in),
    .cp0_rdata              (cp0_rdata),
    .cp0_epc                (cp0_epc),
    .has_int                (has_int),
    .status_exl             (status_exl)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic ex, input logic [4:0] excode, input logic [31:0] bva,
                       input logic bd, input logic [31:0] pc, input logic we,
                       input logic [4:0] addr, input logic [31:0] wdata, input logic eret);
    bus = {ex, excode, bva, bd, pc, we, addr, wdata, eret};
  endtask

  task automatic idle_read(input logic [4:0] addr);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, addr, 32'd0, 1'b0);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, addr, wdata, 1'b0);
  endtask

  task automatic read_check(input logic [4:0] addr, input logic [31:0] exp, input string name);
    @(negedge clk);
    idle_read(addr);
    #1;
    checks++;
    if (cp0_rdata !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, cp0_rdata, exp);
    end
  endtask

  task automatic bit_check(input logic got, input logic exp, input string name);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  // The timer is parked far from a Count/Compare match so TI stays clear outside its own test.
  task automatic park_timer();
`ifdef CP0_TIMER_INT_EN
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'hFFFF_FFFF);
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ext_int_in = 6'd0;
    idle_read(5'd12);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (cp0_rdata !== 32'h0040_0000) begin
      failures++;
      $display("FAIL reset_status: got %08h expected 00400000", cp0_rdata);
    end
    bit_check(has_int, 1'b0, "reset_has_int");
    bit_check(status_exl, 1'b0, "reset_exl");
    idle_read(5'd13);
    #1;
    checks++;
    if (cp0_rdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_cause: got %08h expected 00000000", cp0_rdata);
    end
    park_timer();
    read_check(5'd14, 32'd0, "reset_epc");
    read_check(5'd8, 32'd0, "reset_badvaddr");
  endtask

  task automatic test_exception();
    @(negedge clk);
    drive(1'b1, 5'h04, 32'h0000_0003, 1'b1, 32'hBFC0_0100, 1'b0, 5'd14, 32'd0, 1'b0);
    #1;
    checks++;
    if (cp0_rdata !== 32'd0) begin
      failures++;
      $display("FAIL same_cycle_old_epc: got %08h expected 00000000", cp0_rdata);
    end
    read_check(5'd14, 32'hBFC0_00FC, "ex_epc");
    read_check(5'd13, 32'h8000_0010, "ex_cause");
    read_check(5'd8, 32'h0000_0003, "ex_badvaddr");
    bit_check(status_exl, 1'b1, "ex_exl");
    bit_check(cp0_epc == 32'hBFC0_00FC, 1'b1, "ex_cp0_epc");
  endtask

  task automatic test_nested_ex();
    @(negedge clk);
    drive(1'b1, 5'h08, 32'h1111_1111, 1'b0, 32'h0000_0100, 1'b0, 5'd0, 32'd0, 1'b0);
    read_check(5'd14, 32'hBFC0_00FC, "nested_epc");
    read_check(5'd13, 32'h8000_0020, "nested_cause");
    read_check(5'd8, 32'h0000_0003, "nested_badvaddr");
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    @(negedge clk);
    idle_read(5'd0);
    #1;
    bit_check(status_exl, 1'b0, "eret_exl");
  endtask

  task automatic test_interrupt();
    mtc0(5'd12, 32'h0000_0401);
    @(negedge clk);
    idle_read(5'd12);
    ext_int_in = 6'b000001;
    #1;
    bit_check(has_int, 1'b0, "int_not_before_sample");
    @(negedge clk);
    #1;
    bit_check(has_int, 1'b1, "int_asserted");
    read_check(5'd13, 32'h8000_0420, "int_cause_ip");
    mtc0(5'd12, 32'h0000_0403);
    @(negedge clk);
    idle_read(5'd12);
    #1;
    bit_check(has_int, 1'b0, "int_masked_by_exl");
    ext_int_in = 6'd0;
    mtc0(5'd12, 32'h0000_0000);
    read_check(5'd12, 32'h0040_0000, "status_cleared");
  endtask

  task automatic test_priority();
    @(negedge clk);
    drive(1'b1, 5'h0c, 32'd0, 1'b0, 32'h0000_2000, 1'b1, 5'd14, 32'h0000_1234, 1'b1);
    read_check(5'd14, 32'h0000_2000, "prio_ex_over_mtc0");
    bit_check(status_exl, 1'b1, "prio_ex_over_eret");
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd12, 32'h0000_0001, 1'b1);
    read_check(5'd12, 32'h0040_0000, "prio_eret_over_mtc0");
    mtc0(5'd5, 32'hFFFF_FFFF);
    read_check(5'd5, 32'd0, "unmapped_read");
    mtc0(5'd8, 32'hFFFF_FFFF);
    read_check(5'd8, 32'h0000_0003, "badvaddr_readonly");
  endtask

  task automatic test_random();
    logic [31:0] m_status, m_cause, m_epc, m_bva;
    logic [5:0]  m_ip;
    logic [4:0]  addrs [5];
    logic [4:0]  excs [7];
    addrs = '{5'd5, 5'd8, 5'd12, 5'd13, 5'd14};
    excs  = '{5'h00, 5'h04, 5'h05, 5'h08, 5'h09, 5'h0a, 5'h0c};
    // Start from a known state the model can mirror.
    mtc0(5'd12, 32'h0000_0000);
    mtc0(5'd13, 32'h0000_0000);
    mtc0(5'd14, 32'h0000_0000);
    @(negedge clk);
    drive(1'b1, 5'h04, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    ext_int_in = 6'd0;
    m_status = 32'h0040_0000;
    m_cause  = {1'b0, 24'd0, 5'h04, 2'b00};
    m_epc    = 32'd0;
    m_bva    = 32'd0;
    m_ip     = 6'd0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      logic        ex, eret, we, bd, exp_int;
      logic [4:0]  excode, addr;
      logic [31:0] pc, wdata, bva, exp_rd, cause_rd;
      @(negedge clk);
      ex     = ($urandom_range(0, 7) == 0);
      eret   = ($urandom_range(0, 7) == 0);
      we     = ($urandom_range(0, 1) == 1);
      excode = excs[$urandom_range(0, 6)];
      addr   = addrs[$urandom_range(0, 4)];
      bd     = 1'($urandom);
      pc     = $urandom;
      bva    = $urandom;
      wdata  = $urandom;
      drive(ex, excode, bva, bd, pc, we, addr, wdata, eret);
      ext_int_in = 6'($urandom);
      #1;
      cause_rd = m_cause | (32'(m_ip) << 10);
      case (addr)
        5'd8:    exp_rd = m_bva;
        5'd12:   exp_rd = m_status;
        5'd13:   exp_rd = cause_rd;
        5'd14:   exp_rd = m_epc;
        default: exp_rd = 32'd0;
      endcase
      exp_int = ((cause_rd[15:8] & m_status[15:8]) != 8'd0) && m_status[0] && !m_status[1];
      checks++;
      if (cp0_rdata !== exp_rd || cp0_epc !== m_epc || status_exl !== m_status[1] || has_int !== exp_int) begin
        failures++;
        $display("FAIL random_cyc%0d addr %0d: rdata %08h/%08h epc %08h/%08h exl %0b/%0b int %0b/%0b",
                 cyc, addr, cp0_rdata, exp_rd, cp0_epc, m_epc, status_exl, m_status[1], has_int, exp_int);
      end
      if (ex) begin
        if (!m_status[1]) begin
          m_epc = bd ? pc - 32'd4 : pc;
          m_cause[31] = bd;
        end
        m_status[1] = 1'b1;
        m_cause[6:2] = excode;
        if (excode == 5'h04 || excode == 5'h05) m_bva = bva;
      end else if (eret) begin
        m_status[1] = 1'b0;
      end else if (we) begin
        if (addr == 5'd12) m_status = 32'h0040_0000 | (wdata & 32'h0000_FF03);
        if (addr == 5'd13) m_cause = (m_cause & ~32'h0000_0300) | (wdata & 32'h0000_0300);
        if (addr == 5'd14) m_epc = wdata;
      end
      m_ip = ext_int_in;
    end
    ext_int_in = 6'd0;
  endtask

  task automatic test_timer();
`ifdef CP0_TIMER_INT_EN
    int n;
    logic seen;
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd10);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      idle_read(5'd13);
      #1;
      n++;
      if (cp0_rdata[30] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || n < 17 || n > 23) begin
      failures++;
      $display("FAIL timer_ti_latency: got %0d cycles (seen %0b) expected 17..23", n, seen);
    end
    mtc0(5'd11, 32'd50);
    @(negedge clk);
    idle_read(5'd13);
    #1;
    bit_check(cp0_rdata[30], 1'b0, "timer_ti_cleared");
`endif
  endtask

  task automatic test_reset_override();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 5'h04, 32'hDEAD_BEEF, 1'b0, 32'h1234_5678, 1'b0, 5'd12, 32'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle_read(5'd12);
    #1;
    checks++;
    if (cp0_rdata !== 32'h0040_0000 || cp0_epc !== 32'd0) begin
      failures++;
      $display("FAIL reset_override: status %08h epc %08h expected 00400000 00000000", cp0_rdata, cp0_epc);
    end
    read_check(5'd8, 32'd0, "reset_override_badvaddr");
  endtask

  initial begin
    test_reset();
    test_exception();
    test_nested_ex();
    test_interrupt();
    test_priority();
    test_random();
    test_timer();
    test_reset_override();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
